// File: rtl/bus_cmd_issuer_if.sv
// Command-bus bundle between the controller/memory side and bus_cmd_issuer.
// master is the issuer's view; slave is the environment's view.
interface bus_cmd_issuer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_opcode;
    logic        req_enc_type;
    logic [1:0]  req_dest_id;
    logic [1:0]  req_src_id;
    logic [23:0] req_addr;
    logic        out_bus_valid;
    logic [7:0]  out_bus_data;
    logic        in_bus_ready;
    logic        in_ack_bus_request;
    logic [1:0]  in_ack_bus_id;
    logic        cmd_done;
    logic        cmd_timeout;
    logic        cmd_error;

    modport master (
        input  req_valid, req_opcode, req_enc_type, req_dest_id, req_src_id, req_addr,
        input  in_bus_ready, in_ack_bus_request, in_ack_bus_id,
        output req_ready, out_bus_valid, out_bus_data, cmd_done, cmd_timeout, cmd_error
    );

    modport slave (
        output req_valid, req_opcode, req_enc_type, req_dest_id, req_src_id, req_addr,
        output in_bus_ready, in_ack_bus_request, in_ack_bus_id,
        input  req_ready, out_bus_valid, out_bus_data, cmd_done, cmd_timeout, cmd_error
    );
endinterface

// File: rtl/bus_cmd_issuer.sv
// Serialises one command (header + 3 address bytes) onto the 8-bit command bus,
// then waits for the matching ack and reports done / timeout / error.
module bus_cmd_issuer #(
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input logic              clk,
    input logic              rst,
    bus_cmd_issuer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        SEND_HDR,
        SEND_ADDR,
        WAIT_ACK,
        DONE,
        TOUT,
        ERR
    } state_t;

    localparam logic [1:0]  OP_WR_RES = 2'b10;
    localparam logic [1:0]  OP_OTHER  = 2'b11;
    localparam bit          TOUT_EN   = (ACK_TIMEOUT != 0);
    localparam logic [15:0] TOUT_LAST = TOUT_EN ? 16'(ACK_TIMEOUT - 1) : 16'd0;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [23:0] addr_q, addr_d;
    logic [1:0]  exp_id_q, exp_id_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        tout_q, tout_d;
    logic        err_q, err_d;

    logic        req_ok;
    logic        ack_hit;

    always_comb begin
        req_ok = 1'b0;
        case (bus.req_opcode)
            OP_WR_RES: req_ok = (bus.req_src_id == 2'b00);
            OP_OTHER:  req_ok = 1'b0;
            default:   req_ok = (bus.req_dest_id == 2'b00);
        endcase
        ack_hit = bus.in_ack_bus_request && (bus.in_ack_bus_id == exp_id_q);
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        addr_d     = addr_q;
        exp_id_d   = exp_id_q;
        data_d     = data_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr;
                    exp_id_d = (bus.req_opcode == OP_WR_RES) ? bus.req_src_id : bus.req_dest_id;
                    if (req_ok) begin
                        state_d = SEND_HDR;
                        data_d  = {bus.req_enc_type, 1'b0, bus.req_dest_id,
                                   bus.req_src_id, bus.req_opcode};
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            SEND_HDR: begin
                if (bus.in_bus_ready) begin
                    state_d    = SEND_ADDR;
                    byte_cnt_d = 2'd0;
                    data_d     = addr_q[7:0];
                end
            end
            SEND_ADDR: begin
                // data_q is loaded with the byte for the *next* counter value so it is
                // already stable on the bus the cycle after the handshake.
                if (bus.in_bus_ready) begin
                    if (byte_cnt_q == 2'd2) begin
                        state_d   = WAIT_ACK;
                        tmo_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        data_d     = (byte_cnt_q == 2'd0) ? addr_q[15:8] : addr_q[23:16];
                    end
                end
            end
            WAIT_ACK: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                if (ack_hit) begin
                    state_d = DONE;
                end else if (TOUT_EN && (tmo_cnt_q == TOUT_LAST)) begin
                    state_d = TOUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == SEND_HDR) || (state_d == SEND_ADDR);
        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
        tout_d  = (state_d == TOUT);
        err_d   = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            addr_q     <= '0;
            exp_id_q   <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            tout_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            addr_q     <= addr_d;
            exp_id_q   <= exp_id_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            tout_q     <= tout_d;
            err_q      <= err_d;
        end
    end

    assign bus.req_ready     = ready_q;
    assign bus.out_bus_valid = valid_q;
    assign bus.out_bus_data  = data_q;
    assign bus.cmd_done      = done_q;
    assign bus.cmd_timeout   = tout_q;
    assign bus.cmd_error     = err_q;
endmodule
